uart_tx_scheduler: RTL and testbench

- Shares one UART byte transmitter (clocked from clk50, paced by the baud generator) among N byte-stream requesters.
- Round-robin arbitration at packet granularity: the grant is held until the requester's byte flagged last has been transmitted.
- Gates every byte on the peer's clear-to-send line, flags prolonged CTS stalls, and keeps a transmitted-byte counter for the gpio/debug path.

---
 rtl/uart_tx_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART byte transmitter among N_REQ byte-stream
// requesters. The arbiter is round-robin, and a grant is held for a whole packet.
// Each byte is gated on the peer's active-low CTS. Long CTS stalls raise a sticky
// flag, and a wrapping counter tracks completed bytes.
module uart_tx_scheduler #(
   parameter int N_REQ        = 4,
   parameter int STALL_CYCLES = 5_000_000
) (
   input  logic                 clk50,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 uart_cts,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic                 grant_valid,
   output logic [2:0]           grant_id,
   output logic                 stall_err,
   output logic [15:0]          bytes_sent
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(STALL_CYCLES + 1);
   localparam logic [CW-1:0] STALL_MAX = CW'(STALL_CYCLES);
   localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_CTS = 2'd1,
      SEND     = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [IW-1:0]     owner_r, owner_s;
   logic [IW-1:0]     rr_ptr_r, rr_ptr_s;
   logic              last_r, last_s;
   logic [CW-1:0]     stall_cnt_r, stall_cnt_s;
   logic [N_REQ-1:0]  req_ready_r, req_ready_s;
   logic              tx_start_r, tx_start_s;
   logic [7:0]        tx_data_r, tx_data_s;
   logic              grant_valid_r, grant_valid_s;
   logic [2:0]        grant_id_r, grant_id_s;
   logic              stall_err_r, stall_err_s;
   logic [15:0]       bytes_sent_r, bytes_sent_s;

   logic              hit_s;
   logic [IW-1:0]     win_s;
   logic [7:0]        data_a [N_REQ];

   // Split the flat data bus into one byte per requester.
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_a[g] = req_data[8*g +: 8];
   end

   // Round-robin search: the closest valid requester at or above rr_ptr wins.
   // Walking from farthest to nearest lets the nearest hit overwrite the others.
   always_comb begin
      hit_s = 1'b0;
      win_s = rr_ptr_r;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         logic [IW-1:0] cand;
         cand  = IW'((int'(rr_ptr_r) + k) % N_REQ);
         hit_s = hit_s | req_valid[cand];
         win_s = req_valid[cand] ? cand : win_s;
      end
   end

   // Packet-level FSM: next state and next values of all registered outputs.
   always_comb begin
      state_s       = state_r;
      owner_s       = owner_r;
      rr_ptr_s      = rr_ptr_r;
      last_s        = last_r;
      req_ready_s   = {N_REQ{1'b0}};
      tx_start_s    = 1'b0;
      tx_data_s     = tx_data_r;
      grant_valid_s = grant_valid_r;
      grant_id_s    = grant_id_r;
      bytes_sent_s  = bytes_sent_r;
      case (state_r)
         IDLE: begin
            if (hit_s) begin
               owner_s       = win_s;
               grant_valid_s = 1'b1;
               grant_id_s    = 3'(win_s);
               state_s       = WAIT_CTS;
            end else begin
               grant_valid_s = 1'b0;
            end
         end
         WAIT_CTS: begin
            if (!uart_cts && !tx_busy && req_valid[owner_r]) begin
               tx_start_s           = 1'b1;
               req_ready_s[owner_r] = 1'b1;
               tx_data_s            = data_a[owner_r];
               last_s               = req_last[owner_r];
               state_s              = SEND;
            end else begin
               state_s = WAIT_CTS;
            end
         end
         SEND: begin
            state_s = DONE;
         end
         DONE: begin
            if (!tx_busy) begin
               bytes_sent_s = bytes_sent_r + 16'd1;
               if (last_r) begin
                  grant_valid_s = 1'b0;
                  rr_ptr_s      = (owner_r == LAST_IDX) ? {IW{1'b0}} : owner_r + IW'(1);
                  state_s       = IDLE;
               end else begin
                  state_s = WAIT_CTS;
               end
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // CTS stall watch: count consecutive blocked cycles with a byte pending.
   // The counter saturates and the flag is sticky until reset.
   always_comb begin
      stall_cnt_s = {CW{1'b0}};
      stall_err_s = stall_err_r;
      if (state_r == WAIT_CTS && req_valid[owner_r] && uart_cts) begin
         stall_cnt_s = (stall_cnt_r < STALL_MAX) ? stall_cnt_r + CW'(1) : stall_cnt_r;
         stall_err_s = stall_err_r | (stall_cnt_r >= STALL_MAX - CW'(1));
      end else begin
         stall_cnt_s = {CW{1'b0}};
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk50) begin
      if (reset) begin
         state_r       <= IDLE;
         owner_r       <= {IW{1'b0}};
         rr_ptr_r      <= {IW{1'b0}};
         last_r        <= 1'b0;
         stall_cnt_r   <= {CW{1'b0}};
         req_ready_r   <= {N_REQ{1'b0}};
         tx_start_r    <= 1'b0;
         tx_data_r     <= 8'h00;
         grant_valid_r <= 1'b0;
         grant_id_r    <= 3'd0;
         stall_err_r   <= 1'b0;
         bytes_sent_r  <= 16'h0000;
      end else begin
         state_r       <= state_s;
         owner_r       <= owner_s;
         rr_ptr_r      <= rr_ptr_s;
         last_r        <= last_s;
         stall_cnt_r   <= stall_cnt_s;
         req_ready_r   <= req_ready_s;
         tx_start_r    <= tx_start_s;
         tx_data_r     <= tx_data_s;
         grant_valid_r <= grant_valid_s;
         grant_id_r    <= grant_id_s;
         stall_err_r   <= stall_err_s;
         bytes_sent_r  <= bytes_sent_s;
      end
   end

   assign req_ready   = req_ready_r;
   assign tx_start    = tx_start_r;
   assign tx_data     = tx_data_r;
   assign grant_valid = grant_valid_r;
   assign grant_id    = grant_id_r;
   assign stall_err   = stall_err_r;
   assign bytes_sent  = bytes_sent_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler. It contains a transmitter
// model (busy for a fixed number of cycles after each start) and table-driven
// requesters. A second instance with a short stall limit exercises the CTS stall flag.
module tb_uart_tx_scheduler;

   localparam int N        = 4;
   localparam int BUSY_LEN = 10;

   logic clk50 = 1'b0;
   always #5 clk50 = ~clk50;

   logic           reset;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic           uart_cts;
   logic           tx_busy;

   logic [N-1:0]   req_ready;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           grant_valid;
   logic [2:0]     grant_id;
   logic           stall_err;
   logic [15:0]    bytes_sent;

   logic [N-1:0]   s_req_ready;
   logic           s_tx_start;
   logic [7:0]     s_tx_data;
   logic           s_grant_valid;
   logic [2:0]     s_grant_id;
   logic           s_stall_err;
   logic [15:0]    s_bytes_sent;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int busy_cnt = 0;

   logic [8:0] pkt [N][16];
   int         head [N];
   int         tail [N];
   int         ready_cnt [N];

   logic [7:0] log_data [64];
   logic [2:0] log_gid  [64];
   int         log_cyc  [64];
   int         n_log = 0;

   uart_tx_scheduler #(.N_REQ(N), .STALL_CYCLES(1000)) dut (
      .clk50(clk50), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .uart_cts(uart_cts),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_valid(grant_valid), .grant_id(grant_id), .stall_err(stall_err),
      .bytes_sent(bytes_sent)
   );

   uart_tx_scheduler #(.N_REQ(N), .STALL_CYCLES(50)) dut_stall (
      .clk50(clk50), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(s_req_ready), .uart_cts(uart_cts),
      .tx_start(s_tx_start), .tx_data(s_tx_data), .tx_busy(tx_busy),
      .grant_valid(s_grant_valid), .grant_id(s_grant_id), .stall_err(s_stall_err),
      .bytes_sent(s_bytes_sent)
   );

   // Transmitter model and cycle counter.
   always @(posedge clk50) begin
      cyc <= cyc + 1;
      if (tx_start) busy_cnt <= BUSY_LEN;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         if (head[i] < tail[i]) begin
            req_valid[i]        = 1'b1;
            req_data[8*i +: 8]  = pkt[i][head[i]][7:0];
            req_last[i]         = pkt[i][head[i]][8];
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      pkt[i][tail[i]] = {l, d};
      tail[i]++;
      refresh();
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk50);
      #1;
   endtask

   function automatic bit drained();
      bit ok;
      ok = !grant_valid && !tx_busy;
      for (int i = 0; i < N; i++) if (head[i] != tail[i]) ok = 1'b0;
      return ok;
   endfunction

   task automatic wait_log(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (n_log < n && k < budget) begin tick(1); k++; end
      check_eq({tag, "_wait"}, (n_log >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (!drained() && k < budget) begin tick(1); k++; end
      check_eq({tag, "_idle"}, drained() ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
   endtask

   // Requester side and start monitor, serviced on every falling edge.
   initial begin
      forever begin
         @(negedge clk50);
         if (tx_start && n_log < 64) begin
            log_data[n_log] = tx_data;
            log_gid[n_log]  = grant_id;
            log_cyc[n_log]  = cyc;
            n_log++;
         end
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               ready_cnt[i]++;
               head[i]++;
            end
         end
         refresh();
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0, base, base2, nl;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      uart_cts  = 1'b0;
      for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; ready_cnt[i] = 0; end

      // Reset state
      tick(3);
      check_eq("rst_tx_start", tx_start, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_grant", {grant_valid, grant_id}, 0);
      check_eq("rst_stall", stall_err, 0);
      check_eq("rst_bytes", bytes_sent, 0);
      reset = 1'b0;
      tick(2);

      // Single byte from requester 2
      c0 = cyc;
      push(2, 8'h55, 1'b1);
      wait_log("t1", 1, 20);
      check_eq("t1_latency", log_cyc[0] - c0, 2);
      check_eq("t1_data", log_data[0], 8'h55);
      check_eq("t1_gid", log_gid[0], 2);
      wait_idle("t1", 100);
      check_eq("t1_ready_cnt", ready_cnt[2], 1);
      check_eq("t1_bytes", bytes_sent, 1);
      check_eq("t1_grant_off", grant_valid, 0);

      // Packet hold: requester 0 three bytes while requester 1 waits
      base = n_log;
      push(0, 8'hA1, 1'b0);
      push(0, 8'hA2, 1'b0);
      push(0, 8'hA3, 1'b1);
      push(1, 8'hB1, 1'b1);
      wait_idle("t2", 400);
      check_eq("t2_count", n_log - base, 4);
      for (int k = 0; k < 3; k++) begin
         check_eq("t2_data", log_data[base+k], 8'hA1 + k);
         check_eq("t2_gid", log_gid[base+k], 0);
      end
      check_eq("t2_b_data", log_data[base+3], 8'hB1);
      check_eq("t2_b_gid", log_gid[base+3], 1);
      check_eq("t2_b2b_gap", log_cyc[base+1] - log_cyc[base], BUSY_LEN + 3);
      check_eq("t2_bytes", bytes_sent, 5);

      // Round robin with all four requesters loaded
      do_reset(2);
      tick(1);
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < N; i++) push(i, 8'(16*i + k), 1'b1);
      base = n_log;
      wait_log("t3", base + 5, 300);
      check_eq("t3_gid0", log_gid[base+0], 0);
      check_eq("t3_gid1", log_gid[base+1], 1);
      check_eq("t3_gid2", log_gid[base+2], 2);
      check_eq("t3_gid3", log_gid[base+3], 3);
      check_eq("t3_gid4", log_gid[base+4], 0);
      check_eq("t3_data4", log_data[base+4], 8'h01);
      reset = 1'b1;
      tick(1);
      base2 = n_log;
      tick(1);
      reset = 1'b0;
      wait_log("t3_rst", base2 + 1, 200);
      check_eq("t3_after_rst_gid", log_gid[base2], 0);
      wait_idle("t3", 1000);

      // CTS gating on requester 3
      uart_cts = 1'b1;
      base = n_log;
      push(3, 8'h3C, 1'b1);
      tick(200);
      check_eq("t4_no_start", n_log - base, 0);
      check_eq("t4_grant", {grant_valid, grant_id}, {1'b1, 3'd3});
      check_eq("t4_stall_clear", stall_err, 0);
      c0 = cyc;
      uart_cts = 1'b0;
      wait_log("t4", base + 1, 20);
      check_eq("t4_latency", log_cyc[base] - c0, 1);
      check_eq("t4_data", log_data[base], 8'h3C);
      wait_idle("t4", 100);

      // Stall flag with limit 50
      do_reset(2);
      check_eq("t5_rst_stall", s_stall_err, 0);
      uart_cts = 1'b1;
      c0 = cyc;
      push(1, 8'h77, 1'b1);
      tick(50);
      check_eq("t5_stall_49", s_stall_err, 0);
      tick(1);
      check_eq("t5_stall_50", s_stall_err, 1);
      check_eq("t5_main_stall", stall_err, 0);
      uart_cts = 1'b0;
      wait_idle("t5", 100);
      check_eq("t5_sticky", s_stall_err, 1);
      check_eq("t5_bytes", s_bytes_sent, 1);
      do_reset(2);
      check_eq("t5_cleared", s_stall_err, 0);

      // Reset mid-byte in DONE
      push(0, 8'h98, 1'b1);
      wait_idle("t6a", 100);
      push(0, 8'h99, 1'b1);
      c0 = 0;
      while (!(tx_busy && grant_valid) && c0 < 50) begin tick(1); c0++; end
      check_eq("t6_reach_done", (tx_busy && grant_valid) ? 32'd1 : 32'd0, 1);
      check_eq("t6_pre_bytes", bytes_sent, 1);
      reset = 1'b1;
      tick(1);
      nl = n_log;
      check_eq("t6_rst_outs", {tx_start, req_ready, grant_valid, grant_id, stall_err}, 0);
      check_eq("t6_rst_data", tx_data, 0);
      check_eq("t6_rst_bytes", bytes_sent, 0);
      reset = 1'b0;
      wait_idle("t6", 100);
      check_eq("t6_byte_lost", bytes_sent, 0);
      check_eq("t6_no_restart", n_log - nl, 0);

      // Counter wrap
      force dut.bytes_sent_r = 16'hFFFF;
      tick(1);
      release dut.bytes_sent_r;
      tick(1);
      check_eq("t7_preload", bytes_sent, 16'hFFFF);
      push(2, 8'h5A, 1'b1);
      wait_idle("t7", 100);
      check_eq("t7_wrap", bytes_sent, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
